// File: rtl/tt_slot_mux_ctrl_if.sv
// ---------------------------------------------------------------------------
// tt_slot_mux_ctrl_if
// User pad bundle between the chip pads and the slot mux controller.
//   pad_clk, pad_rst_n : user project clock and reset, forwarded to the slot
//   ui_in, uio_in      : user inputs and bidir inputs, forwarded to the slot
//   uo_out, uio_out    : selected slot outputs and bidir outputs, returned to the pads
//   uio_oe             : selected slot bidir output enables
// Modports: master = pad side (drives the inputs), slave = controller side.
// ---------------------------------------------------------------------------
interface tt_slot_mux_ctrl_if;
    logic       pad_clk;
    logic       pad_rst_n;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output pad_clk, pad_rst_n, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  pad_clk, pad_rst_n, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_slot_mux_ctrl.sv
// ---------------------------------------------------------------------------
// tt_slot_mux_ctrl
// Selects one of N_SLOTS project slots from three asynchronous pad control
// pins, drives the chosen slot's packed input bus and ena, and returns its
// packed output bus to the user pads. Every selection change goes through a
// break-before-make guard during which the new project is held in reset with
// its clock running. Unselected slots are held idle (iw=0, ena=0).
// Ports:
//   clk, rst_n      controller clock, async active-low reset
//   ctrl_sel_rst_n  async pad, low clears the slot address
//   ctrl_sel_inc    async pad, each rising edge advances the slot address
//   ctrl_ena        async pad, high enables the selected slot
//   pad             user pad bundle (forwarded clock/reset/inputs, returned outputs)
//   slot_ena        per-slot enable, one-hot or zero
//   slot_iw         slot k at [18k+17:18k] = {uio_in, ui_in, rst_n, clk}
//   slot_ow         slot k at [24k+23:24k] = {uio_oe, uio_out, uo_out}
//   sel_addr        current slot address
//   active          selected slot is enabled
// ---------------------------------------------------------------------------
module tt_slot_mux_ctrl #(
    parameter int unsigned N_SLOTS      = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ctrl_sel_rst_n,
    input  logic                    ctrl_sel_inc,
    input  logic                    ctrl_ena,
    tt_slot_mux_ctrl_if.slave       pad,
    output logic [N_SLOTS-1:0]      slot_ena,
    output logic [N_SLOTS*18-1:0]   slot_iw,
    input  logic [N_SLOTS*24-1:0]   slot_ow,
    output logic [ADDR_W-1:0]       sel_addr,
    output logic                    active
);

    localparam int unsigned IW_W  = 18;
    localparam int unsigned OW_W  = 24;
    localparam int unsigned CNT_W = $clog2(GUARD_CYCLES + 1);

    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_GUARD    = 2'd1;
    localparam logic [1:0] ST_ACTIVE   = 2'd2;

    logic [1:0]        sel_rst_sync;
    logic [2:0]        inc_sync;
    logic [1:0]        ena_sync;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  guard_cnt;
    logic [CNT_W-1:0]  guard_cnt_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              addr_chg;
    logic              sel_rst_s;
    logic              inc_edge;
    logic              ena_s;
    logic [OW_W-1:0]   ow_sel;

    // Pad synchronisers; the third inc stage is the previous synced value for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_rst_sync <= '0;
            inc_sync     <= '0;
            ena_sync     <= '0;
        end else begin
            sel_rst_sync <= {sel_rst_sync[0], ctrl_sel_rst_n};
            inc_sync     <= {inc_sync[1:0], ctrl_sel_inc};
            ena_sync     <= {ena_sync[0], ctrl_ena};
        end
    end

    assign sel_rst_s = sel_rst_sync[1];
    assign ena_s     = ena_sync[1];
    assign inc_edge  = inc_sync[1] & ~inc_sync[2];

    // Next slot address: address clear wins over a simultaneous increment
    always_comb begin
        addr_nxt = sel_addr;
        if (!sel_rst_s) begin
            addr_nxt = '0;
        end else if (inc_edge) begin
            if (sel_addr == ADDR_W'(N_SLOTS - 1)) begin
                addr_nxt = '0;
            end else begin
                addr_nxt = sel_addr + ADDR_W'(1);
            end
        end
    end

    assign addr_chg = (addr_nxt != sel_addr);

    // State, guard counter and address registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_DISABLED;
            guard_cnt <= '0;
            sel_addr  <= '0;
        end else begin
            state     <= state_nxt;
            guard_cnt <= guard_cnt_nxt;
            sel_addr  <= addr_nxt;
        end
    end

    // Next state: the address register and the FSM see a change on the same edge,
    // so the new slot is never enabled before its guard has run
    always_comb begin
        state_nxt     = state;
        guard_cnt_nxt = guard_cnt;
        if (!ena_s) begin
            state_nxt     = ST_DISABLED;
            guard_cnt_nxt = '0;
        end else begin
            case (state)
                ST_DISABLED: begin
                    state_nxt     = ST_GUARD;
                    guard_cnt_nxt = CNT_W'(GUARD_CYCLES);
                end
                ST_GUARD: begin
                    if (addr_chg) begin
                        guard_cnt_nxt = CNT_W'(GUARD_CYCLES);
                    end else if (guard_cnt <= CNT_W'(1)) begin
                        state_nxt     = ST_ACTIVE;
                        guard_cnt_nxt = '0;
                    end else begin
                        guard_cnt_nxt = guard_cnt - CNT_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (addr_chg) begin
                        state_nxt     = ST_GUARD;
                        guard_cnt_nxt = CNT_W'(GUARD_CYCLES);
                    end
                end
                default: begin
                    state_nxt     = ST_DISABLED;
                    guard_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign active = (state == ST_ACTIVE);

    // Slot side fan-out and return mux; only the addressed slot is ever driven
    always_comb begin
        slot_ena = '0;
        slot_iw  = '0;
        ow_sel   = '0;
        for (int k = 0; k < int'(N_SLOTS); k++) begin
            if (ADDR_W'(k) == sel_addr) begin
                if (state == ST_ACTIVE) begin
                    slot_ena[k]             = 1'b1;
                    slot_iw[k*IW_W +: IW_W] = {pad.uio_in, pad.ui_in, pad.pad_rst_n, pad.pad_clk};
                    ow_sel                  = slot_ow[k*OW_W +: OW_W];
                end else if (state == ST_GUARD) begin
                    // project held in reset with its clock running
                    slot_iw[k*IW_W +: IW_W] = {16'b0, 1'b0, pad.pad_clk};
                end
            end
        end
    end

    assign pad.uo_out  = ow_sel[7:0];
    assign pad.uio_out = ow_sel[15:8];
    assign pad.uio_oe  = ow_sel[23:16];

endmodule

// File: tb/tb_tt_slot_mux_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tt_slot_mux_ctrl
// Scoreboard bench: stimulus pushes the expected enable/disable events of the
// selected slot; a monitor on the falling clock edge pops and compares each
// time 'active' changes, measures the guard length that preceded every enable,
// and checks slot isolation invariants every cycle.
// ---------------------------------------------------------------------------
module tb_tt_slot_mux_ctrl;

    localparam int N  = 16;
    localparam int AW = 4;
    localparam int G  = 4;

    typedef struct {
        bit         rise;
        logic [3:0] addr;
        logic [7:0] uo;
        logic [7:0] uio;
        logic [7:0] oe;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              ctrl_sel_rst_n;
    logic              ctrl_sel_inc;
    logic              ctrl_ena;
    logic [N-1:0]      slot_ena;
    logic [N*18-1:0]   slot_iw;
    logic [N*24-1:0]   slot_ow;
    logic [AW-1:0]     sel_addr;
    logic              active;

    tt_slot_mux_ctrl_if pad_if ();

    tt_slot_mux_ctrl #(
        .N_SLOTS      (N),
        .ADDR_W       (AW),
        .GUARD_CYCLES (G)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena),
        .pad            (pad_if),
        .slot_ena       (slot_ena),
        .slot_iw        (slot_iw),
        .slot_ow        (slot_ow),
        .sel_addr       (sel_addr),
        .active         (active)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_rise(input logic [3:0] a, input logic [23:0] ow);
        exp_t e;
        e.rise = 1'b1;
        e.addr = a;
        e.uo   = ow[7:0];
        e.uio  = ow[15:8];
        e.oe   = ow[23:16];
        exp_q.push_back(e);
    endtask

    task automatic push_fall(input logic [3:0] a);
        exp_t e;
        e.rise = 1'b0;
        e.addr = a;
        e.uo   = 8'h00;
        e.uio  = 8'h00;
        e.oe   = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic inc_pulse();
        ctrl_sel_inc = 1'b1;
        clks(2);
        ctrl_sel_inc = 1'b0;
        clks(1);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected events still pending after %0d cycles at %0t",
                     exp_q.size(), max_cyc, $time);
            exp_q.delete();
        end
    endtask

    // Monitor: per-cycle isolation invariants plus event scoreboard
    bit         prev_active = 1'b0;
    int         prev_addr   = 0;
    int         guard_run   = 0;

    always @(negedge clk) begin
        int          a;
        logic [17:0] siw;
        logic [N*18-1:0] others;
        logic [N-1:0] one;
        logic [N-1:0] ena_req;
        logic [23:0] ow_req;
        bit          ok;
        exp_t        e;

        a      = int'(sel_addr);
        siw    = slot_iw[a*18 +: 18];
        others = slot_iw;
        others[a*18 +: 18] = '0;
        one    = 1;
        ena_req = active ? (one << a) : '0;
        ow_req  = active ? slot_ow[a*24 +: 24] : 24'h0;
        ok = (slot_ena == ena_req) && (others == '0) &&
             (active || siw[17:1] == 17'h0) &&
             ({pad_if.uio_oe, pad_if.uio_out, pad_if.uo_out} == ow_req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL invariant: ena=0x%0h iw_sel=0x%0h out=0x%0h active=%0b addr=%0d at %0t",
                     slot_ena, siw, {pad_if.uio_oe, pad_if.uio_out, pad_if.uo_out}, active, a, $time);
        end

        if (active != prev_active) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: active=%0b addr=%0d expected no event at %0t",
                         active, a, $time);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", 32'(active), 32'(e.rise));
                chk("event_addr", 32'(sel_addr), 32'(e.addr));
                chk("uo_out", 32'(pad_if.uo_out), 32'(e.uo));
                chk("uio_out", 32'(pad_if.uio_out), 32'(e.uio));
                chk("uio_oe", 32'(pad_if.uio_oe), 32'(e.oe));
                if (e.rise) begin
                    chk("guard_len", 32'(guard_run), 32'(G));
                    chk("slot_ena", 32'(slot_ena), 32'(one << e.addr));
                    chk("slot_iw_active", 32'(siw), 32'({8'h96, 8'h5A, 1'b1, 1'b1}));
                end else begin
                    chk("slot_ena_off", 32'(slot_ena), 32'h0);
                end
            end
        end

        // guard pattern: selected slot sees the clock only, reset held, ena low
        if (!active && slot_ena == '0 && siw == 18'h1) begin
            guard_run = (a == prev_addr) ? guard_run + 1 : 1;
        end else begin
            guard_run = 0;
        end
        prev_active = active;
        prev_addr   = a;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        ctrl_sel_rst_n = 1'b1;
        ctrl_sel_inc   = 1'b0;
        ctrl_ena       = 1'b0;
        pad_if.pad_clk   = 1'b1;
        pad_if.pad_rst_n = 1'b1;
        pad_if.ui_in     = 8'h5A;
        pad_if.uio_in    = 8'h96;
        for (int k = 0; k < N; k++) begin
            slot_ow[k*24 +: 24] = 24'hA5C33C ^ {3{8'(k)}};
        end

        // reset state
        #22;
        chk("rst_sel_addr", 32'(sel_addr), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_slot_ena", 32'(slot_ena), 32'h0);
        chk("rst_slot_iw_or", 32'(|slot_iw), 32'h0);
        chk("rst_outputs", 32'({pad_if.uio_oe, pad_if.uio_out, pad_if.uo_out}), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clks(2);

        // enable slot 0 from reset
        push_rise(4'd0, 24'hA5C33C);
        ctrl_ena = 1'b1;
        drain(40);

        // 0 -> 3 while active; guard restarts on each change
        push_fall(4'd1);
        push_rise(4'd3, 24'hA6C03F);
        repeat (3) inc_pulse();
        drain(60);

        // 3 -> 15
        push_fall(4'd4);
        push_rise(4'd15, 24'hAACC33);
        repeat (12) inc_pulse();
        drain(60);

        // 15 -> 0 wrap
        push_fall(4'd0);
        push_rise(4'd0, 24'hA5C33C);
        inc_pulse();
        drain(40);

        // 0 -> 7
        push_fall(4'd1);
        push_rise(4'd7, 24'hA2C43B);
        repeat (7) inc_pulse();
        drain(60);

        // address clear and inc edge together at 7: clear wins
        push_fall(4'd0);
        push_rise(4'd0, 24'hA5C33C);
        ctrl_sel_rst_n = 1'b0;
        ctrl_sel_inc   = 1'b1;
        drain(40);
        ctrl_sel_rst_n = 1'b1;
        ctrl_sel_inc   = 1'b0;
        clks(6);
        chk("sel_rst_hold_addr", 32'(sel_addr), 32'h0);

        // 0 -> 5, then rst_n pulse that never spans a rising clk edge
        push_fall(4'd1);
        push_rise(4'd5, 24'hA0C639);
        repeat (5) inc_pulse();
        drain(60);
        push_fall(4'd0);
        push_rise(4'd0, 24'hA5C33C);
        rst_n = 1'b0;
        #6;
        rst_n = 1'b1;
        drain(40);

        // ena dropped while active, then re-raised
        push_fall(4'd0);
        ctrl_ena = 1'b0;
        drain(20);
        clks(5);
        push_rise(4'd0, 24'hA5C33C);
        ctrl_ena = 1'b1;
        drain(40);

        // ena dropped mid-guard: slot must never come up
        push_fall(4'd0);
        ctrl_ena = 1'b0;
        drain(20);
        clks(5);
        ctrl_ena = 1'b1;
        clks(3);
        ctrl_ena = 1'b0;
        clks(12);
        chk("midguard_active", 32'(active), 32'h0);
        chk("midguard_slot_ena", 32'(slot_ena), 32'h0);
        push_rise(4'd0, 24'hA5C33C);
        ctrl_ena = 1'b1;
        drain(40);

        clks(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
